// File: rtl/vp_key_event_arb.sv
// vp_key_event_arb
// Merges PS/2 keyboard events and joystick numpad level changes into one
// ordered key-event stream. Events are queued in a small FIFO and handed to
// the keymap one at a time. Each event is held off until the keymap reads it,
// or until a timeout expires.
//
// Ports
//   clk_sys       system clock
//   reset         asynchronous, active-high reset
//   flush         synchronous clear of queued and pending events
//   ps2_stb       one-cycle PS/2 event strobe
//   ps2_ascii     PS/2 event code, valid with ps2_stb
//   ps2_released  PS/2 release flag, valid with ps2_stb
//   joy_numpad    joystick numpad levels: bit0..8 = '1'..'9', bit9 = '0'
//   out_read      keymap consumed the presented event (one-cycle pulse)
//   out_stb       one-cycle pulse: new event on out_ascii/out_released
//   out_ascii     presented event code, held until the next out_stb
//   out_released  presented event release flag, held like out_ascii
//   fifo_level    current FIFO occupancy
//   overflow      sticky: a PS/2 event was dropped; cleared by flush
module vp_key_event_arb #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     ps2_stb,
    input  logic [7:0]               ps2_ascii,
    input  logic                     ps2_released,
    input  logic [9:0]               joy_numpad,
    input  logic                     out_read,
    output logic                     out_stb,
    output logic [7:0]               out_ascii,
    output logic                     out_released,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    // Numpad bit index to ASCII digit: bit9 is the '0' key.
    function automatic logic [7:0] f_digit(input logic [3:0] idx);
        return (idx == 4'd9) ? 8'h30 : (8'h31 + {4'h0, idx});
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_timer;
    logic [9:0]      r_joy_s;
    logic [9:0]      r_joy_q;
    logic [9:0]      r_rep;
    logic [9:0]      w_pend;
    logic            w_joy_vld;
    logic [3:0]      w_joy_idx;
    logic            r_hold_vld;
    logic [8:0]      r_hold;
    logic            r_last_joy;
    logic [8:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            w_room;
    logic            w_gnt_ps2;
    logic            w_gnt_joy;
    logic            w_push;
    logic [8:0]      w_push_data;
    logic            w_pop;
    logic            r_out_stb;
    logic [8:0]      r_out;
    logic            r_overflow;

    // Pending joystick changes; the lowest index is offered to the arbiter.
    // A press and release both seen before a grant XOR back to zero.
    assign w_pend = r_joy_q ^ r_rep;

    always_comb begin
        w_joy_vld = 1'b0;
        w_joy_idx = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_joy_vld = 1'b1;
                w_joy_idx = 4'(i);
            end
        end
    end

    // Round-robin between the PS/2 hold and the joystick on a tie.
    assign w_room      = (r_level < LW'(DEPTH));
    assign w_gnt_ps2   = !flush && w_room && r_hold_vld && (!w_joy_vld || r_last_joy);
    assign w_gnt_joy   = !flush && w_room && w_joy_vld && (!r_hold_vld || !r_last_joy);
    assign w_push      = w_gnt_ps2 || w_gnt_joy;
    assign w_push_data = w_gnt_ps2 ? r_hold : {~r_joy_q[w_joy_idx], f_digit(w_joy_idx)};

    // Issue FSM: next state and pop decision.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (out_read || (r_timer == TW'(TIMEOUT - 1))) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_pop       = 1'b0;
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage needs no reset: only entries below the level are ever read.
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_timer    <= '0;
            r_joy_s    <= '0;
            r_joy_q    <= '0;
            r_rep      <= '0;
            r_hold_vld <= 1'b0;
            r_hold     <= '0;
            r_last_joy <= 1'b1;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_out_stb  <= 1'b0;
            r_out      <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Two-stage capture: joystick levels arrive asynchronously.
            r_joy_s   <= joy_numpad;
            r_joy_q   <= r_joy_s;
            r_out_stb <= w_pop;
            r_timer   <= (r_state == S_IDLE || flush) ? '0 : r_timer + 1'b1;

            if (w_pop) begin
                r_out    <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_last_joy <= w_gnt_joy;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase

            // A hold being granted this cycle can take the new event directly.
            if (ps2_stb && (!r_hold_vld || w_gnt_ps2)) begin
                r_hold_vld <= 1'b1;
                r_hold     <= {ps2_released, ps2_ascii};
            end else begin
                if (w_gnt_ps2) begin
                    r_hold_vld <= 1'b0;
                end
                if (ps2_stb) begin
                    r_overflow <= 1'b1;
                end
            end

            if (w_gnt_joy) begin
                r_rep[w_joy_idx] <= r_joy_q[w_joy_idx];
            end

            // Flush overrides everything above; the presented event is kept.
            if (flush) begin
                r_hold_vld <= 1'b0;
                r_rep      <= r_joy_q;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_level    <= '0;
                r_out_stb  <= 1'b0;
                r_overflow <= 1'b0;
            end
        end
    end

    assign out_stb      = r_out_stb;
    assign out_ascii    = r_out[7:0];
    assign out_released = r_out[8];
    assign fifo_level   = r_level;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_vp_key_event_arb.sv
module tb_vp_key_event_arb;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       ps2_stb = 1'b0;
    logic [7:0] ps2_ascii = 8'h00;
    logic       ps2_released = 1'b0;
    logic [9:0] joy_numpad = 10'h000;
    logic       out_read = 1'b0;
    logic       out_stb;
    logic [7:0] out_ascii;
    logic       out_released;
    logic [2:0] fifo_level;
    logic       overflow;

    int    n_checks = 0;
    int    n_errors = 0;
    longint cyc = 0;

    vp_key_event_arb #(.DEPTH(4), .TIMEOUT(1000)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .flush        (flush),
        .ps2_stb      (ps2_stb),
        .ps2_ascii    (ps2_ascii),
        .ps2_released (ps2_released),
        .joy_numpad   (joy_numpad),
        .out_read     (out_read),
        .out_stb      (out_stb),
        .out_ascii    (out_ascii),
        .out_released (out_released),
        .fifo_level   (fifo_level),
        .overflow     (overflow)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_stb(input int bound, output bit found, output int waited);
        found  = 1'b0;
        waited = 0;
        while (!found && waited < bound) begin
            tick();
            waited++;
            if (out_stb === 1'b1) found = 1'b1;
        end
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        flush = 1'b0; ps2_stb = 1'b0; out_read = 1'b0; joy_numpad = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic pulse_read;
        out_read = 1'b1;
        tick();
        out_read = 1'b0;
    endtask

    task automatic test_reset;
        tick(); tick();
        n_checks++;
        if ({out_stb, out_ascii, out_released, fifo_level, overflow} !== 13'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got stb=%b ascii=%h rel=%b lvl=%0d ovf=%b, want all 0",
                     out_stb, out_ascii, out_released, fifo_level, overflow);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (out_stb !== 1'b0 || fifo_level !== 3'd0) begin
                n_errors++;
                $display("FAIL reset_idle: got stb=%b lvl=%0d, want 0/0", out_stb, fifo_level);
            end
        end
    endtask

    task automatic test_single_ps2;
        bit stray;
        apply_reset();
        ps2_ascii = 8'h61; ps2_released = 1'b0; ps2_stb = 1'b1;
        tick();
        ps2_stb = 1'b0;
        n_checks++;
        if (out_stb !== 1'b0) begin
            n_errors++; $display("FAIL ps2_early_n1: got stb=%b want 0", out_stb);
        end
        tick();
        n_checks++;
        if (out_stb !== 1'b0 || fifo_level !== 3'd1) begin
            n_errors++; $display("FAIL ps2_n2: got stb=%b lvl=%0d want 0/1", out_stb, fifo_level);
        end
        tick();
        n_checks++;
        if (out_stb !== 1'b1 || out_ascii !== 8'h61 || out_released !== 1'b0 || fifo_level !== 3'd0) begin
            n_errors++;
            $display("FAIL ps2_issue_n3: got stb=%b ascii=%h rel=%b lvl=%0d want 1/61/0/0",
                     out_stb, out_ascii, out_released, fifo_level);
        end
        tick();
        n_checks++;
        if (out_stb !== 1'b0 || out_ascii !== 8'h61) begin
            n_errors++; $display("FAIL ps2_pulse_width: got stb=%b ascii=%h want 0/61", out_stb, out_ascii);
        end
        tick();
        pulse_read();
        stray = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_stb !== 1'b0) stray = 1'b1;
        end
        n_checks++;
        if (stray || fifo_level !== 3'd0 || out_ascii !== 8'h61) begin
            n_errors++;
            $display("FAIL ps2_after_read: got stray=%b lvl=%0d ascii=%h want 0/0/61", stray, fifo_level, out_ascii);
        end
    endtask

    task automatic test_joy_press_release;
        bit stray;
        apply_reset();
        joy_numpad = 10'h004;
        stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_stb !== 1'b0) stray = 1'b1;
        end
        n_checks++;
        if (stray) begin
            n_errors++; $display("FAIL joy_early: got stb before cycle N+4, want none");
        end
        tick();
        n_checks++;
        if (out_stb !== 1'b1 || out_ascii !== 8'h33 || out_released !== 1'b0) begin
            n_errors++;
            $display("FAIL joy_press_n4: got stb=%b ascii=%h rel=%b want 1/33/0", out_stb, out_ascii, out_released);
        end
        for (int i = 0; i < 16; i++) tick();
        joy_numpad = 10'h000;
        stray = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_stb !== 1'b0) stray = 1'b1;
        end
        n_checks++;
        if (stray || fifo_level !== 3'd1) begin
            n_errors++;
            $display("FAIL joy_release_held: got stray=%b lvl=%0d want 0/1", stray, fifo_level);
        end
        pulse_read();
        tick();
        n_checks++;
        if (out_stb !== 1'b1 || out_ascii !== 8'h33 || out_released !== 1'b1) begin
            n_errors++;
            $display("FAIL joy_release: got stb=%b ascii=%h rel=%b want 1/33/1", out_stb, out_ascii, out_released);
        end
        pulse_read();
    endtask

    task automatic test_contention;
        apply_reset();
        joy_numpad = 10'h002;
        tick();
        ps2_ascii = 8'h78; ps2_released = 1'b0; ps2_stb = 1'b1;
        tick();
        ps2_ascii = 8'h79;
        tick();
        ps2_stb = 1'b0;
        tick();
        n_checks++;
        if (out_stb !== 1'b1 || out_ascii !== 8'h78) begin
            n_errors++; $display("FAIL tie_first: got stb=%b ascii=%h want 1/78", out_stb, out_ascii);
        end
        pulse_read();
        tick();
        n_checks++;
        if (out_stb !== 1'b1 || out_ascii !== 8'h32 || out_released !== 1'b0) begin
            n_errors++;
            $display("FAIL tie_second: got stb=%b ascii=%h rel=%b want 1/32/0", out_stb, out_ascii, out_released);
        end
        pulse_read();
        tick();
        n_checks++;
        if (out_stb !== 1'b1 || out_ascii !== 8'h79) begin
            n_errors++; $display("FAIL tie_third: got stb=%b ascii=%h want 1/79", out_stb, out_ascii);
        end
        pulse_read();
    endtask

    task automatic test_overflow_glitch;
        bit     found;
        int     waited;
        longint t_prev;
        apply_reset();
        t_prev = 0;
        for (int i = 0; i < 7; i++) begin
            ps2_ascii = 8'h41 + 8'(i); ps2_released = 1'b0; ps2_stb = 1'b1;
            tick();
            if (i == 2) begin
                t_prev = cyc;
                n_checks++;
                if (out_stb !== 1'b1 || out_ascii !== 8'h41) begin
                    n_errors++; $display("FAIL ovf_first: got stb=%b ascii=%h want 1/41", out_stb, out_ascii);
                end
            end
            if (i == 5) begin
                n_checks++;
                if (overflow !== 1'b0) begin
                    n_errors++; $display("FAIL ovf_six: got overflow=%b want 0", overflow);
                end
            end
            if (i == 6) begin
                n_checks++;
                if (overflow !== 1'b1) begin
                    n_errors++; $display("FAIL ovf_seven: got overflow=%b want 1", overflow);
                end
            end
        end
        ps2_stb = 1'b0;
        n_checks++;
        if (fifo_level !== 3'd4) begin
            n_errors++; $display("FAIL ovf_level: got %0d want 4", fifo_level);
        end
        joy_numpad = 10'h200;
        tick(); tick();
        joy_numpad = 10'h000;
        for (int k = 1; k <= 5; k++) begin
            wait_stb(1100, found, waited);
            n_checks++;
            if (!found || out_ascii !== (8'h41 + 8'(k)) || out_released !== 1'b0 || (cyc - t_prev) != 1001) begin
                n_errors++;
                $display("FAIL ovf_drain_%0d: got found=%b ascii=%h rel=%b gap=%0d want 1/%h/0/1001",
                         k, found, out_ascii, out_released, cyc - t_prev, 8'h41 + 8'(k));
            end
            t_prev = cyc;
        end
        wait_stb(1100, found, waited);
        n_checks++;
        if (found || overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_tail: got extra_stb=%b ascii=%h ovf=%b want 0/-/1", found, out_ascii, overflow);
        end
    endtask

    task automatic test_flush;
        bit found;
        int waited;
        joy_numpad = 10'h001;
        flush = 1'b1;
        ps2_ascii = 8'h71; ps2_stb = 1'b1;
        tick();
        ps2_stb = 1'b0;
        tick(); tick(); tick();
        flush = 1'b0;
        n_checks++;
        if (overflow !== 1'b0 || fifo_level !== 3'd0 || out_stb !== 1'b0 || out_ascii !== 8'h46) begin
            n_errors++;
            $display("FAIL flush_state: got ovf=%b lvl=%0d stb=%b ascii=%h want 0/0/0/46",
                     overflow, fifo_level, out_stb, out_ascii);
        end
        wait_stb(20, found, waited);
        n_checks++;
        if (found) begin
            n_errors++; $display("FAIL flush_no_press: got stb ascii=%h want none", out_ascii);
        end
        joy_numpad = 10'h000;
        wait_stb(10, found, waited);
        n_checks++;
        if (!found || waited != 4 || out_ascii !== 8'h31 || out_released !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_release: got found=%b lat=%0d ascii=%h rel=%b want 1/4/31/1",
                     found, waited, out_ascii, out_released);
        end
        pulse_read();
    endtask

    task automatic test_reset_mid_wait;
        bit found;
        int waited;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            ps2_ascii = 8'h6B + 8'(i); ps2_released = 1'b1; ps2_stb = 1'b1;
            tick();
        end
        ps2_stb = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (fifo_level !== 3'd3 || out_ascii !== 8'h6B || out_released !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_setup: got lvl=%0d ascii=%h rel=%b want 3/6b/1", fifo_level, out_ascii, out_released);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({out_stb, out_ascii, out_released, fifo_level, overflow} !== 13'h0) begin
            n_errors++;
            $display("FAIL rst_async: got stb=%b ascii=%h rel=%b lvl=%0d ovf=%b want all 0",
                     out_stb, out_ascii, out_released, fifo_level, overflow);
        end
        tick();
        reset = 1'b0;
        wait_stb(20, found, waited);
        n_checks++;
        if (found || fifo_level !== 3'd0) begin
            n_errors++; $display("FAIL rst_lost: got stb=%b lvl=%0d want 0/0", found, fifo_level);
        end
    endtask

    initial begin
        test_reset();
        test_single_ps2();
        test_joy_press_release();
        test_contention();
        test_overflow_glitch();
        test_flush();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
